mux_pipe_reg: RTL

MUX_PIPE_REG -- requirements
Module: mux_pipe_reg

---
 rtl/mux_pipe_reg.sv | 101 ++++++++++
 1 files changed

// File: rtl/mux_pipe_reg.sv
// mux_pipe_reg: N-way channel select feeding one registered output stage.
// Valid/ready handshake on both sides. The stage refills in the same cycle it
// drains, so back-to-back traffic flows with no gap. Selects past the last
// channel load zeros, raise selError and bump a saturating error counter.
module mux_pipe_reg #(
  parameter int unsigned WIDTH      = 5,
  parameter int unsigned NUM_INPUTS = 2,
  parameter int unsigned SEL_W      = (($clog2(NUM_INPUTS) < 1) ? 1 : $clog2(NUM_INPUTS))
) (
  input  logic                        clk,
  input  logic                        rstN,
  input  logic                        flush,
  input  logic [WIDTH*NUM_INPUTS-1:0] inBus,
  input  logic [SEL_W-1:0]            selIn,
  input  logic                        inValid,
  output logic                        inReady,
  output logic [WIDTH-1:0]            outMux,
  output logic                        outValid,
  input  logic                        outReady,
  output logic                        selError,
  output logic [7:0]                  errCount
);

  // Select is widened by one bit so NUM_INPUTS itself is representable in the compare.
  localparam int unsigned CMP_W   = SEL_W + 1;
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             accept;
  logic             release_;
  logic             selOutOfRange;
  logic [WIDTH-1:0] selData;

  logic [WIDTH-1:0] nextMux;
  logic             nextValid;
  logic             nextSelError;
  logic [CNT_W-1:0] nextErrCount;

  // The stage can take an item when it is empty or draining this cycle; flush blocks intake.
  always_comb begin
    inReady  = (!outValid || outReady) && !flush;
    accept   = inValid && inReady;
    release_ = outValid && outReady;
  end

  // Flag selects that name no existing channel.
  always_comb begin
    selOutOfRange = (CMP_W'(selIn) >= CMP_W'(NUM_INPUTS));
  end

  // Channel mux. An out-of-range select matches no channel and leaves the zero default.
  always_comb begin
    selData = '0;
    for (int k = 0; k < int'(NUM_INPUTS); k++) begin
      if (selIn == SEL_W'(k)) begin
        selData = inBus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state for the output stage. Flush takes priority over everything.
  // An accept wins over a release, so accept+release in one cycle replaces the item.
  always_comb begin
    nextMux      = outMux;
    nextValid    = outValid;
    nextSelError = selError;
    nextErrCount = errCount;
    if (flush) begin
      nextMux      = '0;
      nextValid    = 1'b0;
      nextSelError = 1'b0;
    end else if (accept) begin
      nextMux      = selOutOfRange ? '0 : selData;
      nextValid    = 1'b1;
      nextSelError = selOutOfRange;
      if (selOutOfRange && (errCount != CNT_MAX)) begin
        nextErrCount = errCount + CNT_W'(1);
      end
    end else if (release_) begin
      // Data is left in place; only the valid and error flags drop.
      nextValid    = 1'b0;
      nextSelError = 1'b0;
    end
  end

  // Output stage registers; reset clears them immediately, without a clock.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      outMux   <= '0;
      outValid <= 1'b0;
      selError <= 1'b0;
      errCount <= '0;
    end else begin
      outMux   <= nextMux;
      outValid <= nextValid;
      selError <= nextSelError;
      errCount <= nextErrCount;
    end
  end

endmodule
